// File: rtl/uart_pkg.sv
// Shared constants for uart_16450_lite: register addresses, LSR/IER bit indices,
// IIR codes, TX/RX state encodings and the IIR priority encoder.
package uart_pkg;

    localparam logic [2:0] ADDR_RBR_THR = 3'd0;
    localparam logic [2:0] ADDR_IER     = 3'd1;
    localparam logic [2:0] ADDR_IIR     = 3'd2;
    localparam logic [2:0] ADDR_LCR     = 3'd3;
    localparam logic [2:0] ADDR_MCR     = 3'd4;
    localparam logic [2:0] ADDR_LSR     = 3'd5;
    localparam logic [2:0] ADDR_MSR     = 3'd6;
    localparam logic [2:0] ADDR_SCR     = 3'd7;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_FE   = 3;
    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;

    localparam int IER_ERBFI = 0;
    localparam int IER_ETBEI = 1;
    localparam int IER_ELSI  = 2;

    localparam int LCR_DLAB = 7;
    localparam int MCR_LOOP = 4;

    localparam logic [7:0] IIR_NONE = 8'h01;
    localparam logic [7:0] IIR_THRE = 8'h02;
    localparam logic [7:0] IIR_RDA  = 8'h04;
    localparam logic [7:0] IIR_RLS  = 8'h06;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // Highest-priority pending cause wins.
    function automatic logic [7:0] iir_encode(input logic [2:0] ier,
                                              input logic       oe,
                                              input logic       fe,
                                              input logic       dr,
                                              input logic       thre_pend);
        if (ier[IER_ELSI] && (oe || fe))
            return IIR_RLS;
        else if (ier[IER_ERBFI] && dr)
            return IIR_RDA;
        else if (ier[IER_ETBEI] && thre_pend)
            return IIR_THRE;
        else
            return IIR_NONE;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x baud tick generator: down-counter reloading with divisor-1, one-cycle tick at zero.
// Divisor 0 stops the ticks; reload_i forces a fresh count from the current divisor.
module uart_baud_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] divisor_i,
    input  logic        reload_i,
    output logic        tick_o,
    output logic        run_o
);

    logic [15:0] cnt_q, cnt_d;

    assign run_o  = (divisor_i != 16'd0);
    assign tick_o = run_o && (cnt_q == 16'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (reload_i)
            cnt_d = divisor_i - 16'd1;
        else if (run_o)
            cnt_d = (cnt_q == 16'd0) ? (divisor_i - 16'd1) : (cnt_q - 16'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= 16'd0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_16450_lite.sv
// 16450-subset UART, fixed 8N1, with baud divisor, level IRQ and combinational register reads.
// Define UART_LOOPBACK_EN to make MCR[4] loop the TX shifter back into RX and hold txd high.
//
// state    | meaning
// IDLE     | TX: waiting for a pending THR byte / RX: hunting for a low sample
// START    | TX: driving start bit / RX: waiting to re-check the start bit mid-bit
// DATA     | TX: shifting out 8 bits LSB first / RX: sampling 8 bits LSB first
// STOP     | TX: driving stop bit / RX: waiting for the stop-bit sample
module uart_16450_lite
    import uart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET   = 16'd0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic       we,
    input  logic       re,
    input  logic       rxd,
    output logic       txd,
    output logic       irq
);

    logic [7:0] dll_q, dlm_q, lcr_q, scr_q;
    logic [3:0] ier_q;
    logic [4:0] mcr_q;
    logic       reload_q;
    logic       irq_q;

    logic [7:0] thr_q, thr_d, rbr_q, rbr_d;
    logic       dr_q, dr_d, oe_q, oe_d, fe_q, fe_d;
    logic       thre_q, thre_d, temt_q, temt_d;
    logic       thre_pend_q, thre_pend_d;

    tx_state_e  tx_state_q, tx_state_d;
    logic [7:0] tsr_q, tsr_d;
    logic [3:0] tx_tcnt_q, tx_tcnt_d;
    logic [2:0] tx_bcnt_q, tx_bcnt_d;
    logic       tx_load;

    rx_state_e  rx_state_q, rx_state_d;
    logic [7:0] rsr_q, rsr_d;
    logic [3:0] rx_tcnt_q, rx_tcnt_d;
    logic [2:0] rx_bcnt_q, rx_bcnt_d;
    logic       rx_done, rx_stop_bad;

    logic [SYNC_STAGES-1:0] sync_q;
    logic       rx_sync, rx_in, tx_serial;
    logic       tick, baud_run;
    logic       dlab;
    logic       wr_thr, wr_dll, wr_dlm, wr_ier, wr_lcr, wr_mcr, wr_scr;
    logic       rd_rbr, rd_lsr, rd_iir;
    logic [7:0] iir, lsr;

    assign dlab   = lcr_q[LCR_DLAB];
    assign wr_thr = we && (addr == ADDR_RBR_THR) && !dlab;
    assign wr_dll = we && (addr == ADDR_RBR_THR) && dlab;
    assign wr_ier = we && (addr == ADDR_IER) && !dlab;
    assign wr_dlm = we && (addr == ADDR_IER) && dlab;
    assign wr_lcr = we && (addr == ADDR_LCR);
    assign wr_mcr = we && (addr == ADDR_MCR);
    assign wr_scr = we && (addr == ADDR_SCR);
    assign rd_rbr = re && (addr == ADDR_RBR_THR) && !dlab;
    assign rd_lsr = re && (addr == ADDR_LSR);
    assign rd_iir = re && (addr == ADDR_IIR);

    uart_baud_gen u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .divisor_i ({dlm_q, dll_q}),
        .reload_i  (reload_q),
        .tick_o    (tick),
        .run_o     (baud_run)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dll_q    <= DIV_RESET[7:0];
            dlm_q    <= DIV_RESET[15:8];
            ier_q    <= '0;
            lcr_q    <= '0;
            mcr_q    <= '0;
            scr_q    <= '0;
            reload_q <= 1'b0;
            sync_q   <= '1;
        end else begin
            // Delayed one cycle so the counter reloads from the newly written divisor.
            reload_q <= wr_dll || wr_dlm;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rxd};
            if (wr_dll) dll_q <= wdata;
            if (wr_dlm) dlm_q <= wdata;
            if (wr_ier) ier_q <= wdata[3:0];
            if (wr_lcr) lcr_q <= wdata;
            if (wr_mcr) mcr_q <= wdata[4:0];
            if (wr_scr) scr_q <= wdata;
        end
    end

    assign rx_sync   = sync_q[SYNC_STAGES-1];
    assign tx_serial = (tx_state_q == TX_START) ? 1'b0 :
                       (tx_state_q == TX_DATA)  ? tsr_q[0] : 1'b1;

`ifdef UART_LOOPBACK_EN
    assign txd   = mcr_q[MCR_LOOP] ? 1'b1 : tx_serial;
    assign rx_in = mcr_q[MCR_LOOP] ? tx_serial : rx_sync;
`else
    assign txd   = tx_serial;
    assign rx_in = rx_sync;
`endif

    always_comb begin
        tx_state_d = tx_state_q;
        tsr_d      = tsr_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bcnt_d  = tx_bcnt_q;
        thr_d      = thr_q;
        thre_d     = thre_q;
        temt_d     = temt_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            TX_IDLE: tx_load = baud_run && !thre_q;
            TX_START: begin
                if (tick) begin
                    if (tx_tcnt_q == 4'd0) begin
                        tx_state_d = TX_DATA;
                        tx_tcnt_d  = 4'd15;
                        tx_bcnt_d  = 3'd7;
                    end else begin
                        tx_tcnt_d = tx_tcnt_q - 4'd1;
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (tx_tcnt_q == 4'd0) begin
                        tx_tcnt_d = 4'd15;
                        tsr_d     = {1'b0, tsr_q[7:1]};
                        if (tx_bcnt_q == 3'd0)
                            tx_state_d = TX_STOP;
                        else
                            tx_bcnt_d = tx_bcnt_q - 3'd1;
                    end else begin
                        tx_tcnt_d = tx_tcnt_q - 4'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (tx_tcnt_q == 4'd0) begin
                        if (!thre_q) begin
                            tx_load = 1'b1;
                        end else begin
                            tx_state_d = TX_IDLE;
                            temt_d     = 1'b1;
                        end
                    end else begin
                        tx_tcnt_d = tx_tcnt_q - 4'd1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_state_d = TX_START;
            tsr_d      = thr_q;
            tx_tcnt_d  = 4'd15;
            thre_d     = 1'b1;
            temt_d     = 1'b0;
        end
        // A write in the same cycle as a load becomes the next pending byte.
        if (wr_thr) begin
            thr_d  = wdata;
            thre_d = 1'b0;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rsr_d       = rsr_q;
        rx_tcnt_d   = rx_tcnt_q;
        rx_bcnt_d   = rx_bcnt_q;
        rx_done     = 1'b0;
        rx_stop_bad = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (tick && !rx_in) begin
                    rx_state_d = RX_START;
                    rx_tcnt_d  = 4'd7;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_tcnt_q == 4'd0) begin
                        if (rx_in) begin
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_state_d = RX_DATA;
                            rx_tcnt_d  = 4'd15;
                            rx_bcnt_d  = 3'd7;
                        end
                    end else begin
                        rx_tcnt_d = rx_tcnt_q - 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_tcnt_q == 4'd0) begin
                        rx_tcnt_d = 4'd15;
                        rsr_d     = {rx_in, rsr_q[7:1]};
                        if (rx_bcnt_q == 3'd0)
                            rx_state_d = RX_STOP;
                        else
                            rx_bcnt_d = rx_bcnt_q - 3'd1;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q - 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_tcnt_q == 4'd0) begin
                        rx_done     = 1'b1;
                        rx_stop_bad = !rx_in;
                        rx_state_d  = RX_IDLE;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q - 4'd1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign iir = iir_encode(ier_q[2:0], oe_q, fe_q, dr_q, thre_pend_q);

    always_comb begin
        rbr_d       = rbr_q;
        dr_d        = dr_q;
        oe_d        = oe_q;
        fe_d        = fe_q;
        thre_pend_d = thre_pend_q;
        if (rd_rbr) dr_d = 1'b0;
        if (rd_lsr) begin
            oe_d = 1'b0;
            fe_d = 1'b0;
        end
        // A load colliding with an RBR read keeps DR and is not an overrun.
        if (rx_done) begin
            rbr_d = rsr_q;
            dr_d  = 1'b1;
            if (dr_q && !rd_rbr) oe_d = 1'b1;
            if (rx_stop_bad)     fe_d = 1'b1;
        end
        if (wr_thr || (rd_iir && (iir == IIR_THRE)))
            thre_pend_d = 1'b0;
        if ((!thre_q && thre_d) || (wr_ier && wdata[IER_ETBEI] && !ier_q[IER_ETBEI] && thre_q))
            thre_pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q  <= TX_IDLE;
            tsr_q       <= '0;
            tx_tcnt_q   <= '0;
            tx_bcnt_q   <= '0;
            thr_q       <= '0;
            thre_q      <= 1'b1;
            temt_q      <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rsr_q       <= '0;
            rx_tcnt_q   <= '0;
            rx_bcnt_q   <= '0;
            rbr_q       <= '0;
            dr_q        <= 1'b0;
            oe_q        <= 1'b0;
            fe_q        <= 1'b0;
            thre_pend_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tsr_q       <= tsr_d;
            tx_tcnt_q   <= tx_tcnt_d;
            tx_bcnt_q   <= tx_bcnt_d;
            thr_q       <= thr_d;
            thre_q      <= thre_d;
            temt_q      <= temt_d;
            rx_state_q  <= rx_state_d;
            rsr_q       <= rsr_d;
            rx_tcnt_q   <= rx_tcnt_d;
            rx_bcnt_q   <= rx_bcnt_d;
            rbr_q       <= rbr_d;
            dr_q        <= dr_d;
            oe_q        <= oe_d;
            fe_q        <= fe_d;
            thre_pend_q <= thre_pend_d;
            irq_q       <= ~iir[0];
        end
    end

    assign irq = irq_q;

    always_comb begin
        lsr           = 8'h00;
        lsr[LSR_DR]   = dr_q;
        lsr[LSR_OE]   = oe_q;
        lsr[LSR_FE]   = fe_q;
        lsr[LSR_THRE] = thre_q;
        lsr[LSR_TEMT] = temt_q;
    end

    always_comb begin
        rdata = 8'h00;
        case (addr)
            ADDR_RBR_THR: rdata = dlab ? dll_q : rbr_q;
            ADDR_IER:     rdata = dlab ? dlm_q : {4'b0000, ier_q};
            ADDR_IIR:     rdata = iir;
            ADDR_LCR:     rdata = lcr_q;
            ADDR_MCR:     rdata = {3'b000, mcr_q};
            ADDR_LSR:     rdata = lsr;
            ADDR_MSR:     rdata = 8'h00;
            ADDR_SCR:     rdata = scr_q;
            default:      rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_uart_16450_lite.sv
// Directed bench for uart_16450_lite: registers, TX frame timing, RX/overrun/FE,
// false start, interrupts, optional loopback and mid-frame reset.
module tb_uart_16450_lite;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic       rxd = 1'b1;
    logic       txd;
    logic       irq;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_16450_lite dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .we    (we),
        .re    (re),
        .rxd   (rxd),
        .txd   (txd),
        .irq   (irq)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; re = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic peek(input logic [2:0] a, output logic [7:0] d);
        addr = a;
        #1 d = rdata;
    endtask

    task automatic set_div(input logic [15:0] dv);
        bus_wr(3'd3, 8'h80);
        bus_wr(3'd0, dv[7:0]);
        bus_wr(3'd1, dv[15:8]);
        bus_wr(3'd3, 8'h00);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopb, input int bc);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = f[i];
            repeat (bc - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [9:0] fr;
        logic       txd_bad;

        // reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_txd", txd, 1'b1);
        check("rst_irq", irq, 1'b0);
        peek(3'd5, d); check("rst_lsr", d, 8'h60);
        peek(3'd2, d); check("rst_iir", d, 8'h01);
        peek(3'd0, d); check("rst_rbr", d, 8'h00);
        peek(3'd1, d); check("rst_ier", d, 8'h00);

        // register readback
        bus_wr(3'd7, 8'hA5); peek(3'd7, d); check("scr", d, 8'hA5);
        bus_wr(3'd3, 8'h1B); peek(3'd3, d); check("lcr", d, 8'h1B);
        bus_wr(3'd3, 8'h00);
        bus_wr(3'd4, 8'hFF); peek(3'd4, d); check("mcr", d, 8'h1F);
        bus_wr(3'd4, 8'h00);
        bus_wr(3'd2, 8'hFF); peek(3'd2, d); check("iir_ro", d, 8'h01);
        peek(3'd6, d); check("msr", d, 8'h00);
        bus_wr(3'd3, 8'h80); bus_wr(3'd0, 8'h34); bus_wr(3'd1, 8'h12);
        peek(3'd0, d); check("dll", d, 8'h34);
        peek(3'd1, d); check("dlm", d, 8'h12);
        bus_wr(3'd3, 8'h00);

        // TX frame 0x55 at divisor 1
        set_div(16'd1);
        bus_wr(3'd0, 8'h55);
        fr = {1'b1, 8'h55, 1'b0};
        addr = 3'd5;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("tx_bit%0d_c%0d", c / 16, c), txd, fr[c / 16]);
            if (c == 0 || c == 159) check("tx_lsr_busy", rdata, 8'h20);
        end
        @(negedge clk);
        #1;
        check("tx_temt", rdata, 8'h60);
        check("tx_idle_txd", txd, 1'b1);

        // RX frame then overrun
        send_frame(8'hA3, 1'b1, 16);
        repeat (4) @(negedge clk);
        peek(3'd5, d); check("rx1_lsr", d, 8'h61);
        peek(3'd0, d); check("rx1_rbr", d, 8'hA3);
        send_frame(8'h3C, 1'b1, 16);
        repeat (4) @(negedge clk);
        peek(3'd5, d); check("rx2_lsr_oe", d, 8'h63);
        peek(3'd0, d); check("rx2_rbr", d, 8'h3C);
        bus_rd(3'd5, d); check("rx2_lsr_rd", d, 8'h63);
        peek(3'd5, d); check("rx2_oe_clr", d, 8'h61);
        bus_rd(3'd0, d); check("rx2_rbr_rd", d, 8'h3C);
        peek(3'd5, d); check("rx2_dr_clr", d, 8'h60);

        // false start: 4-clk glitch
        @(negedge clk); rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        peek(3'd5, d); check("false_start_lsr", d, 8'h60);

        // THRE interrupt with baud stopped
        set_div(16'd0);
        bus_wr(3'd1, 8'h03);
        check("irq_lat", irq, 1'b0);
        @(negedge clk);
        check("irq_thre", irq, 1'b1);
        peek(3'd2, d); check("iir_thre", d, 8'h02);
        bus_wr(3'd0, 8'h11);
        check("irq_hold", irq, 1'b1);
        @(negedge clk);
        check("irq_thr_clr", irq, 1'b0);
        peek(3'd2, d); check("iir_none", d, 8'h01);
        repeat (5) @(negedge clk);
        check("irq_frozen", irq, 1'b0);
        peek(3'd5, d); check("lsr_frozen", d, 8'h40);

        // RX data interrupt
        bus_wr(3'd1, 8'h01);
        set_div(16'd1);
        send_frame(8'h5A, 1'b1, 16);
        repeat (4) @(negedge clk);
        check("irq_rda", irq, 1'b1);
        peek(3'd2, d); check("iir_rda", d, 8'h04);
        bus_rd(3'd0, d); check("rda_rbr", d, 8'h5A);
        check("irq_rda_hold", irq, 1'b1);
        @(negedge clk);
        check("irq_rda_clr", irq, 1'b0);
        peek(3'd2, d); check("iir_after_rd", d, 8'h01);

        // framing error and line-status interrupt
        bus_wr(3'd1, 8'h05);
        send_frame(8'hC3, 1'b0, 16);
        repeat (20) @(negedge clk);
        peek(3'd5, d); check("fe_lsr", d, 8'h69);
        peek(3'd2, d); check("iir_rls", d, 8'h06);
        check("irq_rls", irq, 1'b1);
        bus_rd(3'd5, d); check("fe_lsr_rd", d, 8'h69);
        peek(3'd2, d); check("iir_rls_clr", d, 8'h04);
        bus_rd(3'd0, d); check("fe_rbr", d, 8'hC3);
        peek(3'd5, d); check("fe_lsr_clr", d, 8'h60);

        // IIR read clears a pending THRE cause
        bus_wr(3'd1, 8'h02);
        @(negedge clk);
        peek(3'd2, d); check("iir_thre2", d, 8'h02);
        bus_rd(3'd2, d); check("iir_rd_thre", d, 8'h02);
        peek(3'd2, d); check("iir_thre_clr", d, 8'h01);
        bus_wr(3'd1, 8'h00);

`ifdef UART_LOOPBACK_EN
        bus_wr(3'd4, 8'h10);
        set_div(16'd2);
        bus_wr(3'd0, 8'h7E);
        txd_bad = 1'b0;
        for (int c = 0; c < 360; c++) begin
            @(negedge clk);
            if (txd !== 1'b1) txd_bad = 1'b1;
        end
        check("lb_txd_high", txd_bad, 1'b0);
        peek(3'd5, d); check("lb_lsr", d, 8'h61);
        peek(3'd0, d); check("lb_rbr", d, 8'h7E);
        bus_rd(3'd0, d);
        bus_wr(3'd4, 8'h00);
        set_div(16'd1);
`else
        txd_bad = 1'b0;
`endif

        // reset mid-frame aborts transmission
        bus_wr(3'd0, 8'hF0);
        repeat (5) @(negedge clk);
        check("mid_start_txd", txd, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_txd", txd, 1'b1);
        peek(3'd5, d); check("mid_rst_lsr", d, 8'h60);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_txd", txd, 1'b1);
        check("post_rst_irq", irq, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
